// File: rtl/lsu_byte_master.sv
// Load/store initiator: splits RV32I byte/half/word accesses into single-byte
// memory cycles and returns little-endian, sign/zero-extended load data.
module lsu_byte_master #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_RESP
    } state_e;

    // Index of the last byte for a given size encoding (N-1).
    function automatic logic [CNT_W-1:0] last_idx(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return CNT_W'(0);
            3'b001, 3'b101: return CNT_W'(1);
            default:        return CNT_W'(3);
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b100:  return {24'd0, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b101:  return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rbuf_q, rbuf_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]        raw_word;

    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        rsp_rdata_d = rsp_rdata_q;
        raw_word    = rbuf_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    f3_d    = req_funct3;
                    addr_d  = req_addr[ADDR_W-1:0];
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    rbuf_d  = '0;
                    state_d = req_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (cnt_q == last_idx(f3_q)) begin
                    cnt_d       = '0;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_READ: begin
                // Read data lags the strobe by one cycle: capture the previous lane.
                if (cnt_q != '0) begin
                    rbuf_d[{cnt_q - CNT_W'(1), 3'b000} +: 8] = mem_rdata;
                end
                if (cnt_q == last_idx(f3_q)) begin
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                raw_word[{last_idx(f3_q), 3'b000} +: 8] = mem_rdata;
                rbuf_d      = raw_word;
                rsp_rdata_d = extend(f3_q, raw_word);
                cnt_d       = '0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with state_q.
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        mem_en_d    = (state_d == S_WRITE) || (state_d == S_READ);
        mem_we_d    = (state_d == S_WRITE);
        mem_addr_d  = mem_en_d ? (addr_d + ADDR_W'(cnt_d)) : '0;
        mem_wdata_d = mem_we_d ? wdata_d[{cnt_d, 3'b000} +: 8] : 8'd0;
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_byte_master.sv
// Scoreboard bench for lsu_byte_master: directed loads/stores against a byte memory model.
module tb_lsu_byte_master;

    localparam int unsigned ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    lsu_byte_master #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte memory with a backdoor write port for preloading.
    logic [7:0]  mem [0:65535];
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = 16'd0;
    logic [7:0]  bd_data = 8'd0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_fail = 0;
    int rsp_count = 0;
    logic [31:0] rsp_q[$];
    logic [23:0] wr_q[$];
    logic [15:0] rd_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a response or memory cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                rsp_count++;
                if (rsp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_rsp: got 0x%08h expected no response", rsp_rdata);
                end else check("rsp_rdata", rsp_rdata, rsp_q.pop_front());
            end
            if (mem_en && mem_we) begin
                if (wr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%04h data 0x%02h expected none", mem_addr, mem_wdata);
                end else check("mem_write", {8'd0, mem_addr, mem_wdata}, {8'd0, wr_q.pop_front()});
            end
            if (mem_en && !mem_we) begin
                if (rd_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_read: got addr 0x%04h expected none", mem_addr);
                end else check("mem_read_addr", {16'd0, mem_addr}, {16'd0, rd_q.pop_front()});
            end
            if (!(mem_en && mem_we)) check("wdata_zero", {24'd0, mem_wdata}, 32'd0);
            check("we_qualified", {31'd0, mem_we & ~mem_en}, 32'd0);
        end
    end

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp, input int hold);
        int  n;
        int  lat;
        int  en_cnt;
        bit  seen;
        n = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        rsp_q.push_back(we ? 32'd0 : exp);
        for (int i = 0; i < n; i++) begin
            if (we) wr_q.push_back({16'(addr + 32'(i)), wdata[8*i +: 8]});
            else    rd_q.push_back(16'(addr + 32'(i)));
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; en_cnt = 0; seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_en) en_cnt++;
            if (rsp_valid) begin seen = 1'b1; lat = c; end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout: got no rsp_valid expected within 20 cycles");
        end
        check("rsp_latency", 32'(lat), we ? 32'(n + 1) : 32'(n + 2));
        check("mem_cycles", 32'(en_cnt), 32'(n));
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                req_valid = (h == 1);
                req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0500; req_wdata = 32'hCAFEF00D;
                @(negedge clk);
                check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                check("hold_rsp_rdata", rsp_rdata, exp);
                check("hold_req_ready", {31'd0, req_ready}, 32'd0);
                check("hold_mem_en", {31'd0, mem_en}, 32'd0);
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);
        check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        bd_write(16'h0200, 8'h80);
        bd_write(16'hFFFE, 8'h11);
        bd_write(16'hFFFF, 8'h22);
        bd_write(16'h0000, 8'h33);
        bd_write(16'h0001, 8'h44);
        for (int i = 0; i < 4; i++) bd_write(16'h0400 + 16'(i), 8'h00);

        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_txn(1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 32'd0, 0);
        check("sw_mem", {mem[16'h0103], mem[16'h0102], mem[16'h0101], mem[16'h0100]}, 32'hDEADBEEF);
        run_txn(1'b0, 3'b000, 32'h0000_0200, 32'd0, 32'hFFFFFF80, 0);
        run_txn(1'b0, 3'b100, 32'h0000_0200, 32'd0, 32'h00000080, 0);
        run_txn(1'b0, 3'b001, 32'h0000_0102, 32'd0, 32'hFFFFDEAD, 0);
        run_txn(1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h0000DEAD, 0);
        run_txn(1'b1, 3'b001, 32'h0000_0301, 32'h12345678, 32'd0, 0);
        check("sh_mem", {16'd0, mem[16'h0302], mem[16'h0301]}, 32'h00005678);
        run_txn(1'b0, 3'b101, 32'h0000_0301, 32'd0, 32'h00005678, 0);
        run_txn(1'b0, 3'b010, 32'h0000_FFFE, 32'd0, 32'h44332211, 0);
        run_txn(1'b0, 3'b011, 32'h1234_FFFE, 32'd0, 32'h44332211, 0);

        rsp_ready = 1'b0;
        run_txn(1'b0, 3'b000, 32'h0000_0200, 32'd0, 32'hFFFFFF80, 3);

        // Reset in the second byte of a word store.
        wr_q.push_back({16'h0400, 8'h44});
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0000_0400; req_wdata = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_en", {31'd0, mem_en}, 32'd0);
        check("arst_mem_we", {31'd0, mem_we}, 32'd0);
        check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("partial_store", {mem[16'h0403], mem[16'h0402], mem[16'h0401], mem[16'h0400]}, 32'h00000044);
        run_txn(1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'h00000044, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rsp_count", 32'(rsp_count), 32'd11);
        check("queues_drained", 32'(rsp_q.size() + wr_q.size() + rd_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_byte_master.md
Name: lsu_byte_master

Overview:
- Load/store initiator between the core's memory stage and a byte-wide, single-port data memory.
- Accepts one load or store request per handshake, using RV32I funct3 encoding.
- Sequences the request as 1, 2 or 4 consecutive byte accesses on the memory port.
- For loads, assembles the bytes little-endian, sign- or zero-extends the result, and returns it on a response handshake.

Parameters:
- ADDR_W, 16: memory-side byte address width (64 KB space); address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  access size/extension (000 B, 001 H, 010 W, 100 BU, 101 HU; others treated as W)
- req_addr  in  32  byte address; only low ADDR_W bits used
- req_wdata  in  32  store data; low bytes used per size
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  extended load data; 0 for stores
- mem_en  out  1  memory access strobe, one byte per cycle
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid the cycle after a read strobe

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; the byte counter and all data registers clear.
  - Outputs: req_ready=1 once in IDLE; rsp_valid=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation abandons the transfer. Bytes of a store already written stay written, and no response is produced.
- Byte count N: 1 for funct3 000/100, 2 for 001/101, 4 for all other encodings.
- States: IDLE, WRITE, READ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1, latch we, funct3, addr and wdata, clear cnt, and go to WRITE (we=1) or READ (we=0).
- WRITE:
  - Each cycle: mem_en=1, mem_we=1, mem_addr=addr+cnt (truncated to ADDR_W), mem_wdata=wdata byte cnt; cnt increments.
  - After the byte with cnt=N-1, go to RESP with rdata=0.
  - Stores occupy exactly N memory cycles. rsp_valid asserts the cycle after the last write.
- READ:
  - Each cycle: mem_en=1, mem_we=0, mem_addr=addr+cnt.
  - The byte for the previous issue is captured from mem_rdata into byte lane cnt-1.
  - After issuing cnt=N-1, go to WAIT.
- WAIT:
  - mem_en=0. Capture the last byte into lane N-1, apply extension into rsp_rdata, and go to RESP.
  - Loads: N issue cycles, plus 1 WAIT cycle, then RESP.
- Extension rules:
  - 000: bits 31:8 = byte0 bit 7.
  - 100: bits 31:8 = 0.
  - 001: bits 31:16 = byte1 bit 7.
  - 101: bits 31:16 = 0.
  - Others: the four bytes as-is, with byte0 at bits 7:0.
- RESP:
  - rsp_valid=1. rsp_rdata stays stable until a rising edge with rsp_ready=1, then go to IDLE.
  - req_ready=0 and mem_en=0 throughout; requests presented during RESP are not accepted.
- Only one transaction is in flight at a time. req_ready is 0 in every state except IDLE. A new request can be accepted at the earliest in the cycle after the response handshake.
- No alignment check: misaligned halfword/word accesses are performed byte-wise at consecutive addresses.
- Address wrap: addr+cnt wraps modulo 2^ADDR_W. Upper req_addr bits are ignored.
- mem_we is never 1 while mem_en=0. mem_wdata=0 in every state except WRITE.

Test Plan:
- Store word: SW 0xDEADBEEF @0x0100.
  - Writes 0x0100=EF, 0x0101=BE, 0x0102=AD, 0x0103=DE on 4 consecutive cycles.
  - rsp_valid on the next cycle with rsp_rdata=0.
- Byte loads: memory 0x0200=0x80.
  - LB -> 0xFFFFFF80; LBU -> 0x00000080.
  - Exactly one read strobe each; rsp_valid 2 cycles after the strobe cycle.
- Halfword loads: memory 0x0102=AD, 0x0103=DE.
  - LH @0x0102 -> 0xFFFFDEAD; LHU -> 0x0000DEAD.
  - SH 0x12345678 @0x0301 (misaligned) writes 0x0301=78 and 0x0302=56.
- Wrap and odd funct3:
  - LW @0xFFFE issues addrs FFFE, FFFF, 0000, 0001 and returns the assembled word.
  - funct3=011 behaves identically to LW.
- Backpressure: rsp_ready held 0 for 3 cycles after a load.
  - rsp_valid and rsp_rdata held constant, req_ready=0, mem_en=0.
  - A req_valid pulse during that time is not accepted.
  - IDLE and req_ready=1 follow the cycle after the rsp_ready handshake.
- Reset mid-store: rst_n driven low during the 2nd byte of SW @0x0400.
  - mem_en, mem_we and rsp_valid go to 0 immediately, asynchronously.
  - Only 0x0400 is modified; no response is ever produced.
  - req_ready=1 after release, and the next LW completes normally.
